// File: rtl/nrisc_ula_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nrisc_ula_pkg
// Brief    : ULA opcodes, flag bit positions and arbiter state encoding.
// Revision : 1.0
// ============================================================================
package nrisc_ula_pkg;

    localparam int ULA_CTRL_W = 4;
    localparam int ULA_FLAG_W = 3;

    localparam logic [3:0] ULA_ADD   = 4'h0;
    localparam logic [3:0] ULA_SUB   = 4'h1;
    localparam logic [3:0] ULA_AND   = 4'h2;
    localparam logic [3:0] ULA_OR    = 4'h3;
    localparam logic [3:0] ULA_XOR   = 4'h4;
    localparam logic [3:0] ULA_NOT   = 4'h5;
    localparam logic [3:0] ULA_SHL   = 4'h6;
    localparam logic [3:0] ULA_SHR   = 4'h7;
    localparam logic [3:0] ULA_PASSB = 4'h8;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/nrisc_ula.sv
`default_nettype none
// ============================================================================
// Module   : NRISC_ULA
// Brief    : Combinational ULA; SUB carry is the borrow, shifts carry the bit out.
// Revision : 1.0
// ============================================================================
module NRISC_ULA
    import nrisc_ula_pkg::*;
#(
    parameter int TAM = 16
) (
    input  logic [TAM-1:0]        ULA_A,
    input  logic [TAM-1:0]        ULA_B,
    input  logic [ULA_CTRL_W-1:0] ULA_ctrl,
    output logic [TAM-1:0]        ULA_OUT,
    output logic [ULA_FLAG_W-1:0] ULA_flags
);

    logic [TAM-1:0] w_res;
    logic           w_carry;

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        case (ULA_ctrl)
            ULA_ADD:   {w_carry, w_res} = {1'b0, ULA_A} + {1'b0, ULA_B};
            ULA_SUB:   {w_carry, w_res} = {1'b0, ULA_A} - {1'b0, ULA_B};
            ULA_AND:   w_res = ULA_A & ULA_B;
            ULA_OR:    w_res = ULA_A | ULA_B;
            ULA_XOR:   w_res = ULA_A ^ ULA_B;
            ULA_NOT:   w_res = ~ULA_A;
            ULA_SHL: begin
                w_res   = ULA_A << 1;
                w_carry = ULA_A[TAM-1];
            end
            ULA_SHR: begin
                w_res   = ULA_A >> 1;
                w_carry = ULA_A[0];
            end
            ULA_PASSB: w_res = ULA_B;
            default:   w_res = '0;
        endcase
    end

    always_comb begin
        ULA_flags         = '0;
        ULA_flags[FLAG_Z] = (w_res == '0);
        ULA_flags[FLAG_N] = w_res[TAM-1];
        ULA_flags[FLAG_C] = w_carry;
    end

    assign ULA_OUT = w_res;

endmodule
`default_nettype wire

// File: rtl/nrisc_ula_rsp_slot.sv
`default_nettype none
// ============================================================================
// Module   : nrisc_ula_rsp_slot
// Brief    : One-entry registered result slot with valid/ready drain.
// Revision : 1.0
// ============================================================================
module nrisc_ula_rsp_slot
    import nrisc_ula_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FLAG_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [FLAG_W-1:0] load_flags,
    input  logic              rsp_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [FLAG_W-1:0] rsp_flags
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [FLAG_W-1:0] r_flags;

    // A load wins over a drain, so a same-cycle drain+grant keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_flags <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= load_data;
            r_flags <= load_flags;
        end else if (rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_valid;
    assign rsp_data  = r_data;
    assign rsp_flags = r_flags;

endmodule
`default_nettype wire

// File: rtl/nrisc_ula_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nrisc_ula_arbiter
// Brief    : Round-robin, lockable two-port arbiter around one NRISC_ULA.
//            Optional grant/conflict counters: NRISC_ULA_ARB_STAT_EN.
// Revision : 1.0
// ============================================================================
module nrisc_ula_arbiter
    import nrisc_ula_pkg::*;
#(
    parameter int TAM    = 16,
    parameter int CTRL_W = 4,
    parameter int FLAG_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic [TAM-1:0]    req_a_0,
    input  logic [TAM-1:0]    req_b_0,
    input  logic [CTRL_W-1:0] req_ctrl_0,
    input  logic              req_lock_0,
    output logic              rsp_valid_0,
    input  logic              rsp_ready_0,
    output logic [TAM-1:0]    rsp_data_0,
    output logic [FLAG_W-1:0] rsp_flags_0,
    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic [TAM-1:0]    req_a_1,
    input  logic [TAM-1:0]    req_b_1,
    input  logic [CTRL_W-1:0] req_ctrl_1,
    input  logic              req_lock_1,
    output logic              rsp_valid_1,
    input  logic              rsp_ready_1,
    output logic [TAM-1:0]    rsp_data_1,
    output logic [FLAG_W-1:0] rsp_flags_1,
    output logic              busy
`ifdef NRISC_ULA_ARB_STAT_EN
    ,
    output logic [15:0]       stat_gnt_0,
    output logic [15:0]       stat_gnt_1,
    output logic [15:0]       stat_conflict
`endif
);

    arb_state_t        r_state;
    logic              r_rr_last;
    logic              w_elig_0;
    logic              w_elig_1;
    logic              w_gnt_0;
    logic              w_gnt_1;
    logic [TAM-1:0]    w_ula_a;
    logic [TAM-1:0]    w_ula_b;
    logic [CTRL_W-1:0] w_ula_ctrl;
    logic [TAM-1:0]    w_ula_out;
    logic [FLAG_W-1:0] w_ula_flags;

    assign w_elig_0 = req_valid_0 && (!rsp_valid_0 || rsp_ready_0);
    assign w_elig_1 = req_valid_1 && (!rsp_valid_1 || rsp_ready_1);

    always_comb begin
        w_gnt_0 = 1'b0;
        w_gnt_1 = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_elig_0 && w_elig_1) begin
                    w_gnt_0 = r_rr_last;
                    w_gnt_1 = !r_rr_last;
                end else begin
                    w_gnt_0 = w_elig_0;
                    w_gnt_1 = w_elig_1;
                end
            end
            ARB_LOCK0: w_gnt_0 = w_elig_0;
            ARB_LOCK1: w_gnt_1 = w_elig_1;
            default: begin
                w_gnt_0 = 1'b0;
                w_gnt_1 = 1'b0;
            end
        endcase
    end

    // r_rr_last names the port granted most recently; the other wins a tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_rr_last <= 1'b1;
        end else if (w_gnt_0) begin
            r_rr_last <= 1'b0;
            r_state   <= req_lock_0 ? ARB_LOCK0 : ARB_IDLE;
        end else if (w_gnt_1) begin
            r_rr_last <= 1'b1;
            r_state   <= req_lock_1 ? ARB_LOCK1 : ARB_IDLE;
        end
    end

    assign req_ready_0 = w_gnt_0;
    assign req_ready_1 = w_gnt_1;
    assign busy        = (r_state != ARB_IDLE);

    assign w_ula_a    = w_gnt_1 ? req_a_1    : req_a_0;
    assign w_ula_b    = w_gnt_1 ? req_b_1    : req_b_0;
    assign w_ula_ctrl = w_gnt_1 ? req_ctrl_1 : req_ctrl_0;

    NRISC_ULA #(
        .TAM (TAM)
    ) u_ula (
        .ULA_A     (w_ula_a),
        .ULA_B     (w_ula_b),
        .ULA_ctrl  (w_ula_ctrl),
        .ULA_OUT   (w_ula_out),
        .ULA_flags (w_ula_flags)
    );

    nrisc_ula_rsp_slot #(
        .DATA_W (TAM),
        .FLAG_W (FLAG_W)
    ) u_slot_0 (
        .clk        (clk),
        .rst        (rst),
        .load       (w_gnt_0),
        .load_data  (w_ula_out),
        .load_flags (w_ula_flags),
        .rsp_ready  (rsp_ready_0),
        .rsp_valid  (rsp_valid_0),
        .rsp_data   (rsp_data_0),
        .rsp_flags  (rsp_flags_0)
    );

    nrisc_ula_rsp_slot #(
        .DATA_W (TAM),
        .FLAG_W (FLAG_W)
    ) u_slot_1 (
        .clk        (clk),
        .rst        (rst),
        .load       (w_gnt_1),
        .load_data  (w_ula_out),
        .load_flags (w_ula_flags),
        .rsp_ready  (rsp_ready_1),
        .rsp_valid  (rsp_valid_1),
        .rsp_data   (rsp_data_1),
        .rsp_flags  (rsp_flags_1)
    );

`ifdef NRISC_ULA_ARB_STAT_EN
    logic [15:0] r_stat_gnt_0;
    logic [15:0] r_stat_gnt_1;
    logic [15:0] r_stat_conflict;

    // With both valid at most one is granted, so every such cycle is a conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_gnt_0    <= '0;
            r_stat_gnt_1    <= '0;
            r_stat_conflict <= '0;
        end else begin
            if (w_gnt_0 && (r_stat_gnt_0 != 16'hFFFF))
                r_stat_gnt_0 <= r_stat_gnt_0 + 16'd1;
            if (w_gnt_1 && (r_stat_gnt_1 != 16'hFFFF))
                r_stat_gnt_1 <= r_stat_gnt_1 + 16'd1;
            if (req_valid_0 && req_valid_1 && (r_stat_conflict != 16'hFFFF))
                r_stat_conflict <= r_stat_conflict + 16'd1;
        end
    end

    assign stat_gnt_0    = r_stat_gnt_0;
    assign stat_gnt_1    = r_stat_gnt_1;
    assign stat_conflict = r_stat_conflict;
`endif

endmodule
`default_nettype wire
